// File: rtl/gen_arb_pkg.sv
// Shared constants, state type and index helper for the generate-case arbiter.
package gen_arb_pkg;

    localparam int ARB_FIXED   = 0;
    localparam int ARB_RR      = 1;
    localparam int ARB_RR_HOLD = 2;
    localparam int MAX_REQ     = 16;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    function automatic logic [3:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (oh[i]) idx = idx | 4'(i);
        return idx;
    endfunction

endpackage

// File: rtl/gen_arb_rr_pick.sv
// Rotating-priority pick: first set request at or above ptr_i, else wrap to the lowest.
module gen_arb_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] win_o
);

    logic [N_REQ-1:0] hi;

    // x & -x isolates the lowest set bit, giving a one-hot result directly.
    assign hi    = req_i & ({N_REQ{1'b1}} << ptr_i);
    assign win_o = (|hi) ? (hi & (~hi + N_REQ'(1))) : (req_i & (~req_i + N_REQ'(1)));

endmodule

// File: rtl/gen_case_arbiter.sv
// N-way request/grant arbiter; the scheme (fixed, round-robin, round-robin with hold
// limit) is chosen at elaboration by a generate case on ARB_MODE.
module gen_case_arbiter
    import gen_arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int ARB_MODE = 1,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDW-1:0]   gnt_id,
    output logic             hold_expired
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [7:0]       hold_q, hold_d;
    logic             gnt_valid_q, hexp_q, hexp_d;

    logic [N_REQ-1:0] arb_req, win;
    logic [IDW-1:0]   win_id, nxt_ptr;
    logic             g_req, g_last, others, release_c, forced, take;

    assign g_req     = |(req & gnt_q);
    assign g_last    = |(last & gnt_q);
    assign others    = |(req & ~gnt_q);
    assign release_c = (state_q == GRANT) && (!g_req || g_last);
    assign forced    = (ARB_MODE == ARB_RR_HOLD) && (state_q == GRANT) && !release_c &&
                       (hold_q == HOLD_LAST) && others;

    // Rotating modes keep the outgoing owner out of the re-arbitration it triggers.
    assign arb_req = ((ARB_MODE != ARB_FIXED) && (state_q == GRANT)) ? (req & ~gnt_q) : req;

    generate
        case (ARB_MODE)
            ARB_FIXED: begin : g_fixed
                assign win = arb_req & (~arb_req + N_REQ'(1));
            end
            ARB_RR, ARB_RR_HOLD: begin : g_rr
                gen_arb_rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
                    .req_i (arb_req),
                    .ptr_i (ptr_q),
                    .win_o (win)
                );
            end
            default: begin : g_bad
                $error("gen_case_arbiter: unsupported ARB_MODE %0d", ARB_MODE);
            end
        endcase
    endgenerate

    assign win_id  = IDW'(oh2idx(MAX_REQ'(win)));
    assign nxt_ptr = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        hexp_d   = 1'b0;
        take     = 1'b0;
        unique case (state_q)
            IDLE: take = |arb_req;
            GRANT: begin
                if (release_c || forced) begin
                    if (|arb_req) begin
                        take = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        hold_d   = '0;
                    end
                end else if ((ARB_MODE == ARB_RR_HOLD) && (hold_q != HOLD_LAST)) begin
                    hold_d = hold_q + 8'd1;
                end
            end
        endcase
        if (take) begin
            state_d  = GRANT;
            gnt_d    = win;
            gnt_id_d = win_id;
            ptr_d    = nxt_ptr;
            hold_d   = '0;
            hexp_d   = forced;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_valid_q <= 1'b0;
            hexp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_valid_q <= |gnt_d;
            hexp_q      <= hexp_d;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_valid    = gnt_valid_q;
    assign gnt_id       = gnt_id_q;
    assign hold_expired = hexp_q;

endmodule
